// File: rtl/riscv_csr_dbg_bridge.sv
// riscv_csr_dbg_bridge: debug-side initiator for the core CSR port.
// Halts the core, performs one CSR access, returns the pre-access value.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   dbg_req_i/gnt_o request handshake (gnt only in IDLE)
//   dbg_addr_i      CSR address, dbg_wdata_i operand, dbg_op_i CSR op
//   dbg_rvalid_o    one-cycle response strobe with dbg_rdata_o / dbg_err_o
//   core_halt_req_o halt request, core_halted_i halt acknowledge
//   csr_access_o    CSR strobe with csr_addr_o / csr_wdata_o / csr_op_o
//   csr_rdata_i     combinational CSR read data
//   dbg_unlock_i    TPR/TCR write unlock (only with DIFT_CSR_GUARD_EN)
//
// Optional feature macro: DIFT_CSR_GUARD_EN (TPR/TCR write guard).

module riscv_csr_dbg_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dbg_req_i,
    output logic        dbg_gnt_o,
    input  logic [11:0] dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    input  logic [1:0]  dbg_op_i,
`ifdef DIFT_CSR_GUARD_EN
    input  logic        dbg_unlock_i,
`endif
    output logic        dbg_rvalid_o,
    output logic [31:0] dbg_rdata_o,
    output logic        dbg_err_o,
    output logic        core_halt_req_o,
    input  logic        core_halted_i,
    output logic        csr_access_o,
    output logic [11:0] csr_addr_o,
    output logic [31:0] csr_wdata_o,
    output logic [1:0]  csr_op_o,
    input  logic [31:0] csr_rdata_i
);

    localparam logic [1:0] CSR_OP_NONE = 2'b00;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HALT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t      state_q,  state_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic [11:0] addr_q,   addr_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [1:0]  op_q,     op_d;
    logic        rej_q,    rej_d;
    logic [31:0] rdata_q,  rdata_d;
    logic        err_q,    err_d;
    logic        gnt_q,    gnt_d;
    logic        halt_q,   halt_d;
    logic        acc_q,    acc_d;
    logic        rvalid_q, rvalid_d;
    logic [1:0]  csr_op_q, csr_op_d;

    logic        guard_hit;
    logic        rej_in;

`ifdef DIFT_CSR_GUARD_EN
    assign guard_hit = !dbg_unlock_i &&
                       ((dbg_addr_i == 12'h700) || (dbg_addr_i == 12'h701));
`else
    assign guard_hit = 1'b0;
`endif

    // Rejected requests still perform the access, but as a pure read.
    assign rej_in = (dbg_op_i != CSR_OP_NONE) &&
                    ((dbg_addr_i[11:10] == 2'b11) || guard_hit);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        rej_d   = rej_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (dbg_req_i && gnt_q) begin
                    addr_d  = dbg_addr_i;
                    wdata_d = dbg_wdata_i;
                    op_d    = dbg_op_i;
                    rej_d   = rej_in;
                    cnt_d   = '0;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (core_halted_i) begin
                    state_d = S_ACCESS;
                end else if (cnt_q == TMO) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACCESS: begin
                rdata_d = csr_rdata_i;
                err_d   = rej_q;
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered: derive them from the next state.
        gnt_d    = (state_d == S_IDLE);
        halt_d   = (state_d != S_IDLE);
        acc_d    = (state_d == S_ACCESS);
        rvalid_d = (state_d == S_RESP);
        csr_op_d = (acc_d && !rej_d) ? op_d : CSR_OP_NONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            op_q     <= CSR_OP_NONE;
            rej_q    <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            gnt_q    <= 1'b1;
            halt_q   <= 1'b0;
            acc_q    <= 1'b0;
            rvalid_q <= 1'b0;
            csr_op_q <= CSR_OP_NONE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            op_q     <= op_d;
            rej_q    <= rej_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            gnt_q    <= gnt_d;
            halt_q   <= halt_d;
            acc_q    <= acc_d;
            rvalid_q <= rvalid_d;
            csr_op_q <= csr_op_d;
        end
    end

    assign dbg_gnt_o       = gnt_q;
    assign dbg_rvalid_o    = rvalid_q;
    assign dbg_rdata_o     = rdata_q;
    assign dbg_err_o       = err_q;
    assign core_halt_req_o = halt_q;
    assign csr_access_o    = acc_q;
    assign csr_addr_o      = addr_q;
    assign csr_wdata_o     = wdata_q;
    assign csr_op_o        = csr_op_q;

endmodule

// File: tb/tb_riscv_csr_dbg_bridge.sv
// tb_riscv_csr_dbg_bridge: scoreboard bench for riscv_csr_dbg_bridge.
// Covers reads, set, timeout, read-only reject, guard and reset.

module tb_riscv_csr_dbg_bridge;

    localparam int TMO = 4;
    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLR   = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dbg_req_i = 1'b0;
    logic        dbg_gnt_o;
    logic [11:0] dbg_addr_i = '0;
    logic [31:0] dbg_wdata_i = '0;
    logic [1:0]  dbg_op_i = '0;
    logic        dbg_unlock_i = 1'b0;
    logic        dbg_rvalid_o;
    logic [31:0] dbg_rdata_o;
    logic        dbg_err_o;
    logic        core_halt_req_o;
    logic        core_halted_i;
    logic        csr_access_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o;
    logic [1:0]  csr_op_o;
    logic [31:0] csr_rdata_i;

    riscv_csr_dbg_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk             (clk),
        .rst             (rst),
        .dbg_req_i       (dbg_req_i),
        .dbg_gnt_o       (dbg_gnt_o),
        .dbg_addr_i      (dbg_addr_i),
        .dbg_wdata_i     (dbg_wdata_i),
        .dbg_op_i        (dbg_op_i),
`ifdef DIFT_CSR_GUARD_EN
        .dbg_unlock_i    (dbg_unlock_i),
`endif
        .dbg_rvalid_o    (dbg_rvalid_o),
        .dbg_rdata_o     (dbg_rdata_o),
        .dbg_err_o       (dbg_err_o),
        .core_halt_req_o (core_halt_req_o),
        .core_halted_i   (core_halted_i),
        .csr_access_o    (csr_access_o),
        .csr_addr_o      (csr_addr_o),
        .csr_wdata_o     (csr_wdata_o),
        .csr_op_o        (csr_op_o),
        .csr_rdata_i     (csr_rdata_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Core halt model: halted hdelay cycles after halt_req, never if !hen.
    int   hcnt = 0;
    int   hdelay = 0;
    logic hen = 1'b1;

    always @(posedge clk) begin
        if (!core_halt_req_o) hcnt <= 0;
        else hcnt <= hcnt + 1;
    end

    assign core_halted_i = hen && (hcnt >= hdelay);

    // CSR file model driven by the DUT's CSR port.
    logic [31:0] mem [4096];
    logic        ld = 1'b1;

    assign csr_rdata_i = mem[csr_addr_o];

    always @(posedge clk) begin
        if (ld) begin
            mem[12'hF10] <= 32'h0000_0043;
            mem[12'hF00] <= 32'h0080_1100;
            mem[12'h300] <= 32'h0000_0006;
            mem[12'h305] <= 32'h0000_0100;
            mem[12'h340] <= 32'hDEAD_BEEF;
            mem[12'h700] <= 32'h0000_A8AA;
            mem[12'h701] <= 32'h0000_0003;
        end else if (csr_access_o) begin
            case (csr_op_o)
                OP_WRITE: mem[csr_addr_o] <= csr_wdata_o;
                OP_SET:   mem[csr_addr_o] <= mem[csr_addr_o] | csr_wdata_o;
                OP_CLR:   mem[csr_addr_o] <= mem[csr_addr_o] & ~csr_wdata_o;
                default:  ;
            endcase
        end
    end

    // Bench-side reference of CSR contents.
    logic [31:0] shadow [4096];

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [1:0]  op;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nacc;
    } exp_t;

    exp_t sb[$];

    int   k = 0;
    int   nacc = 0;
    int   resp_cnt = 0;
    logic post = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            k = 0;
            nacc = 0;
            post = 1'b0;
        end else begin
            if (post) begin
                chk("post_halt", 32'(core_halt_req_o), 32'd0);
                chk("post_gnt", 32'(dbg_gnt_o), 32'd1);
                post = 1'b0;
            end
            if (dbg_req_i && dbg_gnt_o) k = 0;
            else k++;
            if (csr_access_o) begin
                nacc++;
                if (sb.size() > 0) begin
                    chk("acc_op", 32'(csr_op_o), 32'(sb[0].op));
                    chk("acc_addr", 32'(csr_addr_o), 32'(sb[0].addr));
                    chk("acc_wdata", csr_wdata_o, sb[0].wdata);
                end
            end
            if (dbg_rvalid_o) begin
                if (sb.size() == 0) begin
                    chk("spurious_rvalid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rdata", dbg_rdata_o, e.rdata);
                    chk("err", 32'(dbg_err_o), 32'(e.err));
                    chk("latency", 32'(k), 32'(e.lat));
                    chk("n_access", 32'(nacc), 32'(e.nacc));
                end
                nacc = 0;
                post = 1'b1;
                resp_cnt++;
            end
        end
    end

    task automatic wait_resp(input int old);
        int n;
        n = 0;
        while (resp_cnt == old && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (resp_cnt == old) chk("resp_timeout", 32'd1, 32'd0);
    endtask

    task automatic req(input logic [11:0] a, input logic [1:0] op,
                       input logic [31:0] wd, input logic unl,
                       input int d, input logic never);
        exp_t e;
        logic rej;
        int   old;
        rej = (op != OP_NONE) && (a[11:10] == 2'b11);
`ifdef DIFT_CSR_GUARD_EN
        if (op != OP_NONE && !unl && (a == 12'h700 || a == 12'h701))
            rej = 1'b1;
`endif
        e.addr  = a;
        e.wdata = wd;
        e.op    = rej ? OP_NONE : op;
        if (never) begin
            e.rdata = '0;
            e.err   = 1'b1;
            e.lat   = TMO + 2;
            e.nacc  = 0;
        end else begin
            e.rdata = shadow[a];
            e.err   = rej;
            e.lat   = 3 + d;
            e.nacc  = 1;
            if (!rej) begin
                case (op)
                    OP_WRITE: shadow[a] = wd;
                    OP_SET:   shadow[a] = shadow[a] | wd;
                    OP_CLR:   shadow[a] = shadow[a] & ~wd;
                    default:  ;
                endcase
            end
        end
        sb.push_back(e);
        old = resp_cnt;
        @(posedge clk);
        #1;
        hen = !never;
        hdelay = d;
        dbg_addr_i = a;
        dbg_op_i = op;
        dbg_wdata_i = wd;
        dbg_unlock_i = unl;
        dbg_req_i = 1'b1;
        @(posedge clk);
        #1;
        dbg_req_i = 1'b0;
        wait_resp(old);
    endtask

    logic [11:0] alist [7];

    initial begin
        int n;
        alist[0] = 12'hF10; alist[1] = 12'hF00; alist[2] = 12'h300;
        alist[3] = 12'h305; alist[4] = 12'h340; alist[5] = 12'h700;
        alist[6] = 12'h701;
        for (int i = 0; i < 7; i++) shadow[alist[i]] = '0;
        shadow[12'hF10] = 32'h0000_0043;
        shadow[12'hF00] = 32'h0080_1100;
        shadow[12'h300] = 32'h0000_0006;
        shadow[12'h305] = 32'h0000_0100;
        shadow[12'h340] = 32'hDEAD_BEEF;
        shadow[12'h700] = 32'h0000_A8AA;
        shadow[12'h701] = 32'h0000_0003;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(dbg_gnt_o), 32'd1);
        chk("rst_halt", 32'(core_halt_req_o), 32'd0);
        chk("rst_acc", 32'(csr_access_o), 32'd0);
        chk("rst_rvalid", 32'(dbg_rvalid_o), 32'd0);
        chk("rst_rdata", dbg_rdata_o, 32'd0);
        chk("rst_err", 32'(dbg_err_o), 32'd0);
        chk("rst_op", 32'(csr_op_o), 32'd0);
        chk("rst_addr", 32'(csr_addr_o), 32'd0);
        chk("rst_wdata", csr_wdata_o, 32'd0);
        rst = 1'b0;
        ld = 1'b0;

        req(12'hF10, OP_NONE, 32'h0, 1'b0, 0, 1'b0);
        req(12'h300, OP_SET, 32'h1, 1'b0, 0, 1'b0);
        req(12'h300, OP_NONE, 32'h0, 1'b0, 0, 1'b0);
        req(12'h340, OP_NONE, 32'h0, 1'b0, 0, 1'b1);
        req(12'hF00, OP_WRITE, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        req(12'hF00, OP_NONE, 32'h0, 1'b0, 0, 1'b0);
        req(12'h700, OP_WRITE, 32'h1234_5678, 1'b0, 1, 1'b0);
        req(12'h700, OP_NONE, 32'h0, 1'b0, 0, 1'b0);
        req(12'h700, OP_WRITE, 32'h1234_5678, 1'b1, 2, 1'b0);
        req(12'h700, OP_NONE, 32'h0, 1'b0, 0, 1'b0);
        req(12'h340, OP_CLR, 32'h0000_FFFF, 1'b0, 3, 1'b0);

        // Reset while in ACCESS: no response, back to IDLE.
        @(posedge clk);
        #1;
        hen = 1'b1;
        hdelay = 0;
        dbg_addr_i = 12'hF10;
        dbg_op_i = OP_NONE;
        dbg_req_i = 1'b1;
        @(posedge clk);
        #1;
        dbg_req_i = 1'b0;
        n = 0;
        while (!csr_access_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reach", 32'(csr_access_o), 32'd1);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_gnt", 32'(dbg_gnt_o), 32'd1);
        chk("rst_mid_halt", 32'(core_halt_req_o), 32'd0);
        chk("rst_mid_acc", 32'(csr_access_o), 32'd0);
        chk("rst_mid_rvalid", 32'(dbg_rvalid_o), 32'd0);
        #1;
        rst = 1'b0;
        req(12'hF10, OP_NONE, 32'h0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            req(alist[$urandom_range(0, 6)], 2'($urandom_range(0, 3)),
                $urandom, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), 1'b0);
        end

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_csr_dbg_bridge.md
# riscv_csr_dbg_bridge

Debug-side initiator for the core's CSR access port. It accepts single CSR read/write/set/clear requests from the debug interface, halts the core, and issues exactly one CSR access cycle. It then returns the pre-access CSR value and an error flag to the debugger. It sits between the debug unit and the CSR register file, muxed onto the CSR port while the core is halted.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles to wait for the halt acknowledge. Legal range is 1..65535.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `dbg_req_i` input 1: debug request valid.
- `dbg_gnt_o` output 1: request accepted. Asserted only in IDLE.
- `dbg_addr_i` input 12: target CSR address.
- `dbg_wdata_i` input 32: write/set/clear operand.
- `dbg_op_i` input 2: CSR_OP_NONE/WRITE/SET/CLEAR, encoded as in riscv_defines.
- `dbg_rvalid_o` output 1: one-cycle response strobe.
- `dbg_rdata_o` output 32: CSR value sampled in the access cycle, before any write takes effect.
- `dbg_err_o` output 1: error flag, qualified by `dbg_rvalid_o`.
- `core_halt_req_o` output 1: request to halt the core.
- `core_halted_i` input 1: core is halted and its CSR port is free.
- `csr_access_o` output 1: CSR access strobe.
- `csr_addr_o` output 12: CSR address.
- `csr_wdata_o` output 32: CSR write data.
- `csr_op_o` output 2: CSR operation.
- `csr_rdata_i` input 32: CSR read data, combinational in the same cycle.
- `dbg_unlock_i` input 1: DIFT CSR write unlock. Present only with `DIFT_CSR_GUARD_EN`.

## Operation
- The request registers latch addr, wdata and op when `dbg_req_i & dbg_gnt_o`.
- The bridge has four states: IDLE, HALT, ACCESS, RESP.
- **IDLE**
  - `dbg_gnt_o`=1.
  - On handshake, latch the request, clear the timeout counter and go to HALT.
- **HALT**
  - `core_halt_req_o`=1.
  - If `core_halted_i`=1, go to ACCESS.
  - Otherwise, if the counter equals `TIMEOUT_CYCLES`, set err=1 and go to RESP without accessing the CSR.
  - Otherwise, increment the counter.
  - The counter width is $clog2(TIMEOUT_CYCLES+1) and it never wraps.
- **ACCESS**
  - `core_halt_req_o`=1 and `csr_access_o`=1.
  - `csr_addr_o`/`csr_wdata_o` carry the latched values.
  - `csr_op_o` carries the latched op, or CSR_OP_NONE if the request is rejected.
  - Capture `csr_rdata_i` into the response register, then go to RESP.
- **RESP**
  - `core_halt_req_o`=1 and `dbg_rvalid_o`=1 for exactly one cycle.
  - Go to IDLE. `core_halt_req_o` drops in IDLE.
- Rejections:
  - op≠NONE with `addr[11:10]`==2'b11 (read-only space) sets err=1. The access still happens with op=NONE, so `dbg_rdata_o` holds the valid read value.
- Outside ACCESS:
  - `csr_access_o`=0 and `csr_op_o`=CSR_OP_NONE.
  - addr/wdata hold their last latched values.
- `dbg_rdata_o`/`dbg_err_o` hold their last value until the next RESP. They are 0 after a timeout (rdata only).
- If `dbg_req_i` is asserted in HALT, ACCESS or RESP, it is ignored (`gnt`=0). The requester must keep it asserted.
- If `core_halted_i` drops during ACCESS, the access still completes. It is sampled only in HALT.

## Timing
- Reset values:
  - state=IDLE.
  - `dbg_gnt_o`=1.
  - All other outputs 0.
  - `csr_op_o`=CSR_OP_NONE.
  - Counter 0.
  - Latched registers 0.
- Cycle numbering starts at the handshake edge, cycle 0.
- HALT covers cycle 1 onward.
  - With `core_halted_i` high in cycle 1: ACCESS in cycle 2, RESP in cycle 3, IDLE in cycle 4.
  - Minimum request-to-response latency is 3 cycles.
  - Minimum back-to-back request spacing is 4 cycles.
- Timeout:
  - Halted never rises, so RESP with err=1 occurs in cycle `TIMEOUT_CYCLES`+2.
- A CSR write takes effect at the edge ending ACCESS.
- Reset asserted in any state takes effect at the next edge:
  - The bridge returns to IDLE.
  - `core_halt_req_o` and `csr_access_o` deassert.
  - No response is issued.

## Configuration
- `DIFT_CSR_GUARD_EN` defined:
  - Requests with op≠NONE to 0x700 (TPR) or 0x701 (TCR) while `dbg_unlock_i`=0 are rejected like read-only writes.
  - err=1, the access is performed with op=NONE, and rdata is valid.
  - The `dbg_unlock_i` port is present and is sampled at the handshake.
- `DIFT_CSR_GUARD_EN` undefined:
  - The `dbg_unlock_i` port is absent.
  - TPR/TCR are writable like any other read-write CSR.

## Test plan
- **Read mhartid:**
  - Stimulus: `dbg_op`=NONE, addr=0xF10, `core_halted_i` tied 1, core_id=3, cluster_id=2.
  - Response: rvalid in cycle 3, rdata=0x00000043, err=0, `csr_access_o` high only in cycle 2.
- **SET on mstatus:**
  - Stimulus: op=SET, addr=0x300, wdata=0x1, with IE=0.
  - Response: rdata=0x00000006, err=0; a following read returns 0x00000007.
- **Halt timeout:**
  - Stimulus: `TIMEOUT_CYCLES`=4, `core_halted_i`=0.
  - Response: rvalid with err=1 in cycle 6, `csr_access_o` never asserted, halt_req deasserted in cycle 7.
- **Read-only write:**
  - Stimulus: op=WRITE, addr=0xF00, wdata=0xFFFFFFFF.
  - Response: err=1, rdata=0x00801100, `csr_op_o`=NONE during ACCESS.
- **Guard (`DIFT_CSR_GUARD_EN`):**
  - Stimulus: op=WRITE, addr=0x700, wdata=0x12345678.
  - With unlock=0: err=1 and TPR remains 0x0000A8AA.
  - Repeat with unlock=1: err=0, rdata=0x0000A8AA, and a subsequent read returns 0x12345678.
- **Reset mid-operation:**
  - Stimulus: assert `rst` in ACCESS.
  - Response: no rvalid; next cycle `dbg_gnt_o`=1 and halt_req=0; a new request completes normally.
